// File: rtl/sseg_scan_decoder_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns (abcdefg), the capture FSM
// state encoding, elevator floor one-hot codes and anode helper functions.
package sseg_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h60;
  localparam logic [6:0] SEG_C     = 7'h31;
  localparam logic [6:0] SEG_D     = 7'h42;
  localparam logic [6:0] SEG_E     = 7'h30;
  localparam logic [6:0] SEG_F     = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] FLOOR_1 = 3'b001;
  localparam logic [2:0] FLOOR_2 = 3'b010;
  localparam logic [2:0] FLOOR_3 = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } state_e;

  // Exactly one anode driven low.
  function automatic logic an_is_valid(input logic [3:0] an);
    logic [3:0] act;
    act = ~an;
    return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational decode of one active-low 7-segment pattern into a hex nibble,
// with flags for a recognised glyph and for an all-off (blank) digit.
module sseg_pattern_decode
  import sseg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic       blank,
  output logic [3:0] val
);

  always_comb begin
    ok    = 1'b1;
    blank = 1'b0;
    val   = 4'h0;
    case (seg)
      SEG_0:     val = 4'h0;
      SEG_1:     val = 4'h1;
      SEG_2:     val = 4'h2;
      SEG_3:     val = 4'h3;
      SEG_4:     val = 4'h4;
      SEG_5:     val = 4'h5;
      SEG_6:     val = 4'h6;
      SEG_7:     val = 4'h7;
      SEG_8:     val = 4'h8;
      SEG_9:     val = 4'h9;
      SEG_A:     val = 4'hA;
      SEG_B:     val = 4'hB;
      SEG_C:     val = 4'hC;
      SEG_D:     val = 4'hD;
      SEG_E:     val = 4'hE;
      SEG_F:     val = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers the four digits shown on a multiplexed 7-seg bus (NUM/AN) and flags completed
// scan frames and stale displays. Optional floor decode enabled by SSEG_DECODE_FLOOR_EN.
module sseg_scan_decoder
  import sseg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  NUM,
  input  logic [3:0]  AN,
  output logic [15:0] digit_val,
  output logic [3:0]  digit_ok,
  output logic [3:0]  digit_blank,
  output logic        frame_valid,
  output logic        stale
`ifdef SSEG_DECODE_FLOOR_EN
  ,
  output logic [2:0]  floor_req,
  output logic        floor_ok
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES);

  logic [6:0]       num_in_q, num_in_d, num_prev_q, num_prev_d;
  logic [3:0]       an_in_q, an_in_d, an_prev_q, an_prev_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      digit_val_q, digit_val_d;
  logic [3:0]       digit_ok_q, digit_ok_d;
  logic [3:0]       digit_blank_q, digit_blank_d;
  logic [3:0]       seen_q, seen_d;
  logic             frame_valid_q, frame_valid_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic       an_valid, unchanged, capture, fire;
  logic [1:0] idx;
  logic       dec_ok, dec_blank;
  logic [3:0] dec_val;

  sseg_pattern_decode u_decode (
    .seg   (num_in_q),
    .ok    (dec_ok),
    .blank (dec_blank),
    .val   (dec_val)
  );

  always_comb begin
    num_in_d   = NUM;
    an_in_d    = AN;
    num_prev_d = num_in_q;
    an_prev_d  = an_in_q;
    an_valid   = an_is_valid(an_in_q);
    idx        = an_index(an_in_q);
    unchanged  = (num_in_q == num_prev_q) && (an_in_q == an_prev_q);
  end

  // Capture FSM: a digit is taken once AN and NUM have held still for SETTLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (an_valid) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!an_valid) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!unchanged) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q == SETTLE_MAX) begin
          capture = 1'b1;
          state_d = ST_CAPTURED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURED: begin
        cnt_d = '0;
        if (!an_valid) begin
          state_d = ST_IDLE;
        end else if (!unchanged) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A capture landing in the pulse cycle seeds the fresh mask instead of being dropped.
  always_comb begin
    fire          = (seen_q == 4'hF);
    frame_valid_d = fire;
    seen_d        = fire ? 4'h0 : seen_q;
    digit_val_d   = digit_val_q;
    digit_ok_d    = digit_ok_q;
    digit_blank_d = digit_blank_q;
    if (capture) begin
      seen_d[idx]                     = 1'b1;
      digit_val_d[{idx, 2'b00} +: 4]  = dec_val;
      digit_ok_d[idx]                 = dec_ok;
      digit_blank_d[idx]              = dec_blank;
    end
    if (fire)                  to_cnt_d = '0;
    else if (to_cnt_q == TO_MAX) to_cnt_d = to_cnt_q;
    else                       to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_in_q      <= SEG_BLANK;
      num_prev_q    <= SEG_BLANK;
      an_in_q       <= 4'hF;
      an_prev_q     <= 4'hF;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      digit_val_q   <= '0;
      digit_ok_q    <= '0;
      digit_blank_q <= '0;
      seen_q        <= '0;
      frame_valid_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      num_in_q      <= num_in_d;
      num_prev_q    <= num_prev_d;
      an_in_q       <= an_in_d;
      an_prev_q     <= an_prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digit_val_q   <= digit_val_d;
      digit_ok_q    <= digit_ok_d;
      digit_blank_q <= digit_blank_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign digit_val   = digit_val_q;
  assign digit_ok    = digit_ok_q;
  assign digit_blank = digit_blank_q;
  assign frame_valid = frame_valid_q;
  assign stale       = (to_cnt_q == TO_MAX);

`ifdef SSEG_DECODE_FLOOR_EN
  logic [2:0] floor_req_q, floor_req_d;
  logic       floor_ok_q, floor_ok_d;

  // Floor request comes from the rightmost digit of each completed frame.
  always_comb begin
    floor_req_d = floor_req_q;
    floor_ok_d  = floor_ok_q;
    if (fire) begin
      floor_req_d = 3'b000;
      floor_ok_d  = 1'b0;
      if (digit_ok_q[0]) begin
        case (digit_val_q[3:0])
          4'd1:    begin floor_req_d = FLOOR_1; floor_ok_d = 1'b1; end
          4'd2:    begin floor_req_d = FLOOR_2; floor_ok_d = 1'b1; end
          4'd3:    begin floor_req_d = FLOOR_3; floor_ok_d = 1'b1; end
          default: begin floor_req_d = 3'b000;  floor_ok_d = 1'b0; end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      floor_req_q <= 3'b000;
      floor_ok_q  <= 1'b0;
    end else begin
      floor_req_q <= floor_req_d;
      floor_ok_q  <= floor_ok_d;
    end
  end

  assign floor_req = floor_req_q;
  assign floor_ok  = floor_ok_q;
`endif

endmodule
